// File: rtl/instr_fetch_unit_if.sv
// Fetch-stage bus: instruction-memory read port, IR handshake to the decoder,
// and the redirect input from execute.
interface instr_fetch_unit_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              mem_rd;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;
  logic [DATA_W-1:0] ir;
  logic [ADDR_W-1:0] ir_pc;
  logic              ir_valid;
  logic              ir_ready;
  logic              redirect;
  logic [ADDR_W-1:0] redirect_addr;

  // fetch unit side
  modport master (
    output mem_rd, mem_addr, ir, ir_pc, ir_valid,
    input  mem_ack, mem_rdata, ir_ready, redirect, redirect_addr
  );

  // memory / decoder / execute side
  modport slave (
    input  mem_rd, mem_addr, ir, ir_pc, ir_valid,
    output mem_ack, mem_rdata, ir_ready, redirect, redirect_addr
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, issues one memory read at a time, holds
// the fetched word for the decoder and handles redirects. A request that is
// outstanding when a redirect arrives is drained and its data dropped.
module instr_fetch_unit #(
  parameter int               ADDR_W   = 16,
  parameter int               DATA_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input logic                clk,
  input logic                rst_n,
  instr_fetch_unit_if.master bus
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_HOLD, S_DRAIN} state_t;

  state_t            r_state,    w_state_nx;
  logic [ADDR_W-1:0] r_pc,       w_pc_nx;
  logic [ADDR_W-1:0] r_mem_addr, w_mem_addr_nx;
  logic              r_mem_rd,   w_mem_rd_nx;
  logic [DATA_W-1:0] r_ir,       w_ir_nx;
  logic [ADDR_W-1:0] r_ir_pc,    w_ir_pc_nx;
  logic              r_ir_valid, w_ir_valid_nx;

  logic w_xfer;
  assign w_xfer = r_ir_valid & bus.ir_ready;

  // Next-state and datapath update; redirect outranks everything else.
  always_comb begin
    w_state_nx    = r_state;
    w_pc_nx       = r_pc;
    w_mem_addr_nx = r_mem_addr;
    w_ir_nx       = r_ir;
    w_ir_pc_nx    = r_ir_pc;
    w_ir_valid_nx = r_ir_valid;
    unique case (r_state)
      S_IDLE: begin
        // a late ack left over from before reset is ignored here
        w_state_nx = S_FETCH;
        if (bus.redirect) begin
          w_pc_nx       = bus.redirect_addr;
          w_mem_addr_nx = bus.redirect_addr;
        end else begin
          w_mem_addr_nx = r_pc;
        end
      end
      S_FETCH: begin
        if (bus.redirect) begin
          w_pc_nx       = bus.redirect_addr;
          w_ir_valid_nx = 1'b0;
          if (bus.mem_ack) begin
            // the request just completed, so the new one can start at once
            w_mem_addr_nx = bus.redirect_addr;
            w_state_nx    = S_FETCH;
          end else begin
            // the bus has no cancel, so wait out the stale response
            w_state_nx = S_DRAIN;
          end
        end else if (bus.mem_ack) begin
          w_ir_nx       = bus.mem_rdata;
          w_ir_pc_nx    = r_mem_addr;
          w_ir_valid_nx = 1'b1;
          w_pc_nx       = r_pc + 1'b1;
          w_state_nx    = S_HOLD;
        end
      end
      S_HOLD: begin
        if (bus.redirect) begin
          w_pc_nx       = bus.redirect_addr;
          w_ir_valid_nx = 1'b0;
          w_mem_addr_nx = bus.redirect_addr;
          w_state_nx    = S_FETCH;
        end else if (w_xfer) begin
          w_ir_valid_nx = 1'b0;
          w_mem_addr_nx = r_pc;
          w_state_nx    = S_FETCH;
        end
      end
      S_DRAIN: begin
        // the latest redirect target wins
        if (bus.redirect) w_pc_nx = bus.redirect_addr;
        w_ir_valid_nx = 1'b0;
        if (bus.mem_ack) begin
          w_mem_addr_nx = bus.redirect ? bus.redirect_addr : r_pc;
          w_state_nx    = S_FETCH;
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
    w_mem_rd_nx = (w_state_nx == S_FETCH) || (w_state_nx == S_DRAIN);
  end

  // State and output registers; every output comes straight from a flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_pc       <= RESET_PC;
      r_mem_addr <= RESET_PC;
      r_mem_rd   <= 1'b0;
      r_ir       <= '0;
      r_ir_pc    <= '0;
      r_ir_valid <= 1'b0;
    end else begin
      r_state    <= w_state_nx;
      r_pc       <= w_pc_nx;
      r_mem_addr <= w_mem_addr_nx;
      r_mem_rd   <= w_mem_rd_nx;
      r_ir       <= w_ir_nx;
      r_ir_pc    <= w_ir_pc_nx;
      r_ir_valid <= w_ir_valid_nx;
    end
  end

  assign bus.mem_rd   = r_mem_rd;
  assign bus.mem_addr = r_mem_addr;
  assign bus.ir       = r_ir;
  assign bus.ir_pc    = r_ir_pc;
  assign bus.ir_valid = r_ir_valid;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed corner cases followed by a randomized
// run checked against a program-order model of the fetched stream.
module tb_instr_fetch_unit;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  instr_fetch_unit_if #(.ADDR_W(16), .DATA_W(16)) bus ();

  instr_fetch_unit #(.ADDR_W(16), .DATA_W(16), .RESET_PC(16'h0000)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // memory contents as a pure function of the address
  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'h5A3C;
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic fetch_one(input logic [15:0] d);
    bus.mem_ack = 1'b1; bus.mem_rdata = d; bus.ir_ready = 1'b1;
    tick();
    bus.mem_ack = 1'b0;
    tick();
  endtask

  // model / history for the random phase
  logic [15:0] exp_pc;
  logic        p_valid, p_rd, p_ack, p_redir, p_ready;
  logic [15:0] p_addr, p_ra, p_ir, p_irpc;
  int          n_deliv;

  initial begin
    bus.mem_ack = 1'b0; bus.mem_rdata = '0; bus.ir_ready = 1'b0;
    bus.redirect = 1'b0; bus.redirect_addr = '0;

    // reset state
    repeat (3) tick();
    chk("rst_mem_rd",   bus.mem_rd,   1'b0);
    chk("rst_mem_addr", bus.mem_addr, 16'h0000);
    chk("rst_ir",       bus.ir,       16'h0000);
    chk("rst_ir_pc",    bus.ir_pc,    16'h0000);
    chk("rst_ir_valid", bus.ir_valid, 1'b0);

    // first fetch with same-cycle ack
    rst_n = 1'b1;
    tick();
    chk("f0_mem_rd",   bus.mem_rd,   1'b1);
    chk("f0_mem_addr", bus.mem_addr, 16'h0000);
    bus.mem_ack = 1'b1; bus.mem_rdata = 16'h1A05; bus.ir_ready = 1'b1;
    tick();
    bus.mem_ack = 1'b0;
    chk("f0_ir_valid", bus.ir_valid, 1'b1);
    chk("f0_ir",       bus.ir,       16'h1A05);
    chk("f0_ir_pc",    bus.ir_pc,    16'h0000);
    chk("f0_hold_rd",  bus.mem_rd,   1'b0);
    tick();
    chk("f1_mem_addr", bus.mem_addr, 16'h0001);
    chk("f1_mem_rd",   bus.mem_rd,   1'b1);
    chk("f1_ir_valid", bus.ir_valid, 1'b0);

    // decoder stall in HOLD
    bus.mem_ack = 1'b1; bus.mem_rdata = 16'h1111; bus.ir_ready = 1'b0;
    tick();
    bus.mem_ack = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("stall_ir",    bus.ir,       16'h1111);
      chk("stall_ir_pc", bus.ir_pc,    16'h0001);
      chk("stall_valid", bus.ir_valid, 1'b1);
      chk("stall_rd",    bus.mem_rd,   1'b0);
      tick();
    end
    bus.ir_ready = 1'b1;
    tick();
    chk("stall_next_addr", bus.mem_addr, 16'h0002);
    fetch_one(16'h2222);
    chk("f3_mem_addr", bus.mem_addr, 16'h0003);

    // redirect while waiting -> drain stale request
    bus.redirect = 1'b1; bus.redirect_addr = 16'h0040;
    tick();
    bus.redirect = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("drain_rd",    bus.mem_rd,   1'b1);
      chk("drain_addr",  bus.mem_addr, 16'h0003);
      chk("drain_valid", bus.ir_valid, 1'b0);
      tick();
    end
    bus.mem_ack = 1'b1; bus.mem_rdata = 16'h3333;
    tick();
    bus.mem_ack = 1'b0;
    chk("drain_new_addr", bus.mem_addr, 16'h0040);
    chk("drain_new_rd",   bus.mem_rd,   1'b1);
    chk("drain_drop",     bus.ir_valid, 1'b0);
    tick();
    chk("drain_drop2",    bus.ir_valid, 1'b0);

    // redirect coincident with ack
    bus.mem_ack = 1'b1; bus.mem_rdata = 16'h4444;
    bus.redirect = 1'b1; bus.redirect_addr = 16'h0080;
    tick();
    bus.mem_ack = 1'b0; bus.redirect = 1'b0;
    chk("rack_addr",  bus.mem_addr, 16'h0080);
    chk("rack_rd",    bus.mem_rd,   1'b1);
    chk("rack_valid", bus.ir_valid, 1'b0);
    tick();
    chk("rack_valid2", bus.ir_valid, 1'b0);

    // two redirects inside one drain
    bus.redirect = 1'b1; bus.redirect_addr = 16'h0010;
    tick();
    bus.redirect_addr = 16'h0020;
    tick();
    bus.redirect = 1'b0;
    tick();
    bus.mem_ack = 1'b1; bus.mem_rdata = 16'h5555;
    tick();
    bus.mem_ack = 1'b0;
    chk("dd_addr", bus.mem_addr, 16'h0020);
    bus.mem_ack = 1'b1; bus.mem_rdata = 16'h2020; bus.ir_ready = 1'b0;
    tick();
    bus.mem_ack = 1'b0;
    chk("dd_valid", bus.ir_valid, 1'b1);
    chk("dd_ir",    bus.ir,       16'h2020);
    chk("dd_ir_pc", bus.ir_pc,    16'h0020);
    bus.ir_ready = 1'b1;
    tick();
    chk("dd_next", bus.mem_addr, 16'h0021);

    // PC wrap at 16'hFFFF
    bus.mem_ack = 1'b1; bus.mem_rdata = 16'h6666;
    bus.redirect = 1'b1; bus.redirect_addr = 16'hFFFF;
    tick();
    bus.mem_ack = 1'b0; bus.redirect = 1'b0;
    chk("wrap_addr", bus.mem_addr, 16'hFFFF);
    bus.mem_ack = 1'b1; bus.mem_rdata = 16'hBEEF; bus.ir_ready = 1'b0;
    tick();
    bus.mem_ack = 1'b0;
    chk("wrap_ir_pc", bus.ir_pc, 16'hFFFF);
    chk("wrap_ir",    bus.ir,    16'hBEEF);
    bus.ir_ready = 1'b1;
    tick();
    chk("wrap_next", bus.mem_addr, 16'h0000);
    chk("wrap_rd",   bus.mem_rd,   1'b1);

    // async reset mid-fetch, late ack after release
    bus.mem_ack = 1'b1; bus.mem_rdata = 16'h7777;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_rd",    bus.mem_rd,   1'b0);
    chk("arst_valid", bus.ir_valid, 1'b0);
    chk("arst_ir",    bus.ir,       16'h0000);
    chk("arst_addr",  bus.mem_addr, 16'h0000);
    tick();
    rst_n = 1'b1;
    tick();
    bus.mem_ack = 1'b0;
    chk("late_ack_valid", bus.ir_valid, 1'b0);
    chk("late_ack_rd",    bus.mem_rd,   1'b1);
    chk("late_ack_addr",  bus.mem_addr, 16'h0000);
    tick();
    chk("late_ack_valid2", bus.ir_valid, 1'b0);

    // randomized run: delivered stream must follow program order from the
    // last redirect, and data must match memory at the delivered address
    exp_pc = 16'h0000; n_deliv = 0;
    p_valid = 1'b0; p_rd = bus.mem_rd; p_ack = 1'b0; p_redir = 1'b0; p_ready = 1'b0;
    p_addr = bus.mem_addr; p_ra = '0; p_ir = bus.ir; p_irpc = bus.ir_pc;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (bus.ir_valid && !p_valid) begin
        chk("rnd_ir_pc", bus.ir_pc, exp_pc);
        chk("rnd_ir",    bus.ir,    mem_word(bus.ir_pc));
        exp_pc = bus.ir_pc + 16'h1;
        n_deliv++;
      end
      if (p_redir) begin
        chk("rnd_redir_valid", bus.ir_valid, 1'b0);
        chk("rnd_redir_rd",    bus.mem_rd,   1'b1);
        if (p_valid || p_ack) chk("rnd_redir_addr", bus.mem_addr, p_ra);
      end
      if (p_rd && !p_ack && bus.mem_rd) chk("rnd_addr_stable", bus.mem_addr, p_addr);
      if (p_valid && !p_ready && !p_redir) begin
        chk("rnd_hold_valid", bus.ir_valid, 1'b1);
        chk("rnd_hold_ir",    bus.ir,       p_ir);
        chk("rnd_hold_pc",    bus.ir_pc,    p_irpc);
      end
      if (bus.mem_rd && bus.ir_valid) chk("rnd_rd_valid_excl", 1'b1, 1'b0);

      bus.mem_ack       = bus.mem_rd && ($urandom_range(0, 2) == 0);
      bus.mem_rdata     = bus.mem_ack ? mem_word(bus.mem_addr) : 16'($urandom);
      bus.ir_ready      = $urandom_range(0, 1) == 1;
      bus.redirect      = $urandom_range(0, 11) == 0;
      bus.redirect_addr = 16'($urandom);
      if (bus.redirect) exp_pc = bus.redirect_addr;

      p_valid = bus.ir_valid; p_rd = bus.mem_rd; p_ack = bus.mem_ack;
      p_redir = bus.redirect; p_ready = bus.ir_ready; p_addr = bus.mem_addr;
      p_ra = bus.redirect_addr; p_ir = bus.ir; p_irpc = bus.ir_pc;
      tick();
    end
    chk("rnd_progress", n_deliv > 0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
